// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the serial subtractor
//
// Contents:
//   state_t        FSM state encoding (IDLE / SHIFT / DONE)
//   DEFAULT_WIDTH  default operand width in bits
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle between a requester and the serial subtractor
//
// Signals:
//   start      requester -> subtractor  begin a subtraction (sampled while ready=1)
//   A, B, Bin  requester -> subtractor  minuend, subtrahend, borrow in
//   ready      subtractor -> requester  idle, start will be accepted
//   done       subtractor -> requester  one-cycle pulse, Diff/Bout (and Ovf) valid
//   Diff, Bout subtractor -> requester  registered result A-B-Bin and borrow out
//   Ovf        subtractor -> requester  two's-complement overflow, only with SERIAL_SUB_OVERFLOW_EN
// Modports: master (requester side), slave (subtractor side).
interface serial_subtractor_if
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             Ovf;

   modport master (output start, A, B, Bin, input ready, done, Diff, Bout, Ovf);
   modport slave  (input start, A, B, Bin, output ready, done, Diff, Bout, Ovf);
`else
   modport master (output start, A, B, Bin, input ready, done, Diff, Bout);
   modport slave  (input start, A, B, Bin, output ready, done, Diff, Bout);
`endif

endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor
//
// Ports:
//   A, B  input  minuend and subtrahend bits
//   Bin   input  borrow in
//   Diff  output A ^ B ^ Bin
//   Bout  output borrow out: (~A & B) | (~(A ^ B) & Bin)
module full_subtractor (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic Diff,
   output logic Bout
);

   assign Diff = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, LSB first, one bit per clock
//
// Parameters:
//   WIDTH  operand width, 2..64
// Ports:
//   clk    clock, all state on the rising edge
//   rst    synchronous active-high reset, wins over start
//   bus    serial_subtractor_if.slave: start/A/B/Bin in, ready/done/Diff/Bout out
// Optional feature macro SERIAL_SUB_OVERFLOW_EN adds bus.Ovf (signed overflow,
// registered together with Diff).
// Timing: start accepted at edge k, Diff/Bout loaded at edge k+WIDTH with DONE,
// back in IDLE at edge k+WIDTH+1.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Holds the WIDTH-1 result bits produced so far; the final bit is
   // concatenated on top when Diff is loaded.
   logic [WIDTH-2:0] d_sr;
   logic [WIDTH-1:0] d_next;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             bit_d;
   logic             bit_br;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             ready;
   logic             done;

   full_subtractor u_fs (
      .A    (a_sr[0]),
      .B    (b_sr[0]),
      .Bin  (br),
      .Diff (bit_d),
      .Bout (bit_br)
   );

   assign last   = (cnt == CW'(WIDTH - 1));
   assign d_next = {bit_d, d_sr};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SHIFT;
         SHIFT:   if (last)      state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      ready = 1'b0;
      done  = 1'b0;
      case (state)
         IDLE:    ready = 1'b1;
         DONE:    done  = 1'b1;
         default: ;
      endcase
   end

   assign bus.ready = ready;
   assign bus.done  = done;
   assign bus.Diff  = diff_q;
   assign bus.Bout  = bout_q;

   // Datapath: operand shift registers, borrow flop, counter, result registers.
   // Diff/Bout are only written on the final SHIFT edge so partial results
   // never appear on the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         d_sr   <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sr <= bus.A;
                  b_sr <= bus.B;
                  br   <= bus.Bin;
                  d_sr <= '0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               br   <= bit_br;
               d_sr <= d_next[WIDTH-1:1];
               cnt  <= cnt + CW'(1);
               if (last) begin
                  diff_q <= d_next;
                  bout_q <= bit_br;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic ovf_q;

   // On the last SHIFT cycle a_sr[0]/b_sr[0] are the original operand MSBs
   // and bit_d is the result MSB, so no extra copy of the operands is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state == SHIFT && last) begin
         ovf_q <= (a_sr[0] ^ b_sr[0]) & (bit_d ^ a_sr[0]);
      end
   end

   assign bus.Ovf = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the legal range SHALL be 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled only while ready=1.
REQ-005 The block SHALL have port A, input, WIDTH bits: the minuend.
REQ-006 The block SHALL have port B, input, WIDTH bits: the subtrahend.
REQ-007 The block SHALL have port Bin, input, 1 bit: the borrow input.
REQ-008 The block SHALL have port ready, output, 1 bit: high when the block is idle and can accept start.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that a result is valid.
REQ-010 The block SHALL have port Diff, output, WIDTH bits: the registered result A-B-Bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port Bout, output, 1 bit: the registered borrow out, set to 1 when A < B+Bin (unsigned).

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; ready SHALL equal 1 only in IDLE.
REQ-013 In IDLE with start=1 at edge k, the block SHALL latch A, B and Bin into internal shift registers and the borrow flop, clear the bit counter, and enter SHIFT.
REQ-014 In SHIFT, each cycle SHALL process exactly one bit, LSB first: d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
REQ-015 Result bits SHALL shift in from the MSB side, so that after WIDTH cycles bit i sits at position i.
REQ-016 After the WIDTH-th SHIFT cycle, the block SHALL enter DONE, and Diff and Bout SHALL be loaded at that same edge.
REQ-017 done SHALL be high only in DONE, exactly one cycle, at cycle k+WIDTH+1 relative to the accepting edge k; DONE SHALL then return to IDLE unconditionally.
REQ-018 start SHALL be ignored in SHIFT and DONE; operand changes after acceptance SHALL NOT affect the result.
REQ-019 Diff and Bout SHALL hold their value from the accepting edge until the next DONE load; partial results SHALL never be visible on them.
REQ-020 Back-to-back operation SHALL be supported: start held high SHALL be accepted on the IDLE cycle following DONE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-021 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter, shift registers, borrow flop, Diff, Bout and done to 0; ready SHALL be 1 in the following cycle.
REQ-022 rst SHALL take priority over start.
REQ-023 Reset during SHIFT SHALL abort the operation with no done pulse.

Configuration
REQ-024 With SERIAL_SUB_OVERFLOW_EN defined, the block SHALL add output port Ovf, 1 bit, registered with Diff: Ovf = (A[MSB]!=B[MSB]) && (Diff[MSB]!=A[MSB]), the two's-complement overflow, with reset value 0.
REQ-025 Without SERIAL_SUB_OVERFLOW_EN, port Ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the default-width constant.
REQ-027 The one-bit difference/borrow logic SHALL be a sub-module full_subtractor with ports A, B, Bin, Diff, Bout, instantiated once.
REQ-028 The counter width SHALL be $clog2(WIDTH+1).

Verification (WIDTH=8)
REQ-029 The bench SHALL cover: A=0x05, B=0x03, Bin=0, start at edge 0 -> done high at cycle 9 only, Diff=0x02, Bout=0.
REQ-030 The bench SHALL cover: A=0x03, B=0x05, Bin=0 -> Diff=0xFE, Bout=1.
REQ-031 The bench SHALL cover: A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout=1.
REQ-032 The bench SHALL cover: a second start with A=0xFF, B=0x00 during SHIFT of the 0x05-0x03 case -> ignored, Diff=0x02, exactly one done.
REQ-033 The bench SHALL cover: rst pulsed in the 4th SHIFT cycle -> no done pulse, Diff=0x00, Bout=0, ready=1 in the next cycle, and a new operation after that completes correctly.
REQ-034 The bench SHALL cover, with SERIAL_SUB_OVERFLOW_EN defined: A=0x80, B=0x01 -> Diff=0x7F, Ovf=1, Bout=0; then A=0x10, B=0x01 -> Ovf=0.
